// File: rtl/arith_pkg.sv
// Shared definitions for the sequential multiply/divide unit: FSM encoding,
// operation codes and the default datapath width.
package arith_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_RUN  = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement: dout = neg ? (~din + cin) : din.
// cin lets two instances chain into one double-width negation.
module cond_negate
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic [WIDTH-1:0] din,
    input  logic             neg,
    input  logic             cin,
    output logic [WIDTH-1:0] dout
);

    assign dout = neg ? (~din + {{(WIDTH-1){1'b0}}, cin}) : din;

endmodule

// File: rtl/arith_seq.sv
// Sequential signed/unsigned multiplier (shift-add) and restoring divider
// sharing one WIDTH-bit adder/subtractor and a pair of conditional negators.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for Start; operands captured on Start
// PREP  | take operand magnitudes, record result signs, clear acc/counter
// RUN   | WIDTH iterations of shift-add (mul) or shift-subtract (div)
// FIX   | apply result signs, load result registers
// DONE  | one-cycle Done pulse, Busy low, back to IDLE
module arith_seq
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             S_or_U,
    input  logic             OpCode,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] ArithAnswerOne,
    output logic [WIDTH-1:0] ArithAnswerTwo
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_cap, b_cap;
    logic             signed_cap, op_cap;
    logic [WIDTH-1:0] acc, qreg, opnd;
    logic             sign_res, sign_a;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] res_one, res_two;
    logic             div_zero;

    logic             div_by_zero;
    logic [WIDTH-1:0] add_x, add_y;
    logic             add_sub;
    logic [WIDTH:0]   add_sum;
    logic             trial_ok;

    logic [WIDTH-1:0] neg0_in, neg1_in, neg0_out, neg1_out;
    logic             neg0_en, neg1_en, neg1_cin;

    assign div_by_zero = (op_cap == OP_DIV) && (b_cap == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (Start) state_nxt = ST_PREP;
            ST_PREP: state_nxt = div_by_zero ? ST_DONE : ST_RUN;
            ST_RUN:  if (cnt == LAST_STEP) state_nxt = ST_FIX;
            ST_FIX:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign Busy = (state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX);
    assign Done = (state == ST_DONE);

    // Divide compares the shifted remainder {acc, q msb} against the divisor;
    // when acc's msb is set the shifted value exceeds any divisor, so the
    // dropped top bit only ever forces success.
    assign add_sub  = (op_cap == OP_DIV);
    assign add_x    = add_sub ? {acc[WIDTH-2:0], qreg[WIDTH-1]} : acc;
    assign add_y    = add_sub ? ~opnd : opnd;
    assign add_sum  = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_sub};
    assign trial_ok = acc[WIDTH-1] | add_sum[WIDTH];

    always_comb begin
        neg0_in  = qreg;
        neg0_en  = sign_res;
        neg1_in  = acc;
        neg1_en  = sign_res;
        neg1_cin = (qreg == '0);
        if (state == ST_PREP) begin
            neg0_in  = a_cap;
            neg0_en  = signed_cap & a_cap[WIDTH-1];
            neg1_in  = b_cap;
            neg1_en  = signed_cap & b_cap[WIDTH-1];
            neg1_cin = 1'b1;
        end else if (op_cap == OP_DIV) begin
            neg1_en  = sign_a;
            neg1_cin = 1'b1;
        end
    end

    cond_negate #(.WIDTH(WIDTH)) u_neg_lo (
        .din  (neg0_in),
        .neg  (neg0_en),
        .cin  (1'b1),
        .dout (neg0_out)
    );

    cond_negate #(.WIDTH(WIDTH)) u_neg_hi (
        .din  (neg1_in),
        .neg  (neg1_en),
        .cin  (neg1_cin),
        .dout (neg1_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_cap      <= '0;
            b_cap      <= '0;
            signed_cap <= 1'b0;
            op_cap     <= OP_MUL;
            acc        <= '0;
            qreg       <= '0;
            opnd       <= '0;
            sign_res   <= 1'b0;
            sign_a     <= 1'b0;
            cnt        <= '0;
            res_one    <= '0;
            res_two    <= '0;
            div_zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (Start) begin
                        a_cap      <= A;
                        b_cap      <= B;
                        signed_cap <= S_or_U;
                        op_cap     <= OpCode;
                    end
                end
                ST_PREP: begin
                    cnt      <= '0;
                    acc      <= '0;
                    sign_res <= neg0_en ^ neg1_en;
                    sign_a   <= neg0_en;
                    if (op_cap == OP_MUL) begin
                        opnd <= neg0_out;
                        qreg <= neg1_out;
                    end else begin
                        qreg <= neg0_out;
                        opnd <= neg1_out;
                    end
                    if (div_by_zero) begin
                        res_one  <= '1;
                        res_two  <= a_cap;
                        div_zero <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_cap == OP_MUL) begin
                        if (qreg[0]) begin
                            {acc, qreg} <= {add_sum, qreg[WIDTH-1:1]};
                        end else begin
                            {acc, qreg} <= {1'b0, acc, qreg[WIDTH-1:1]};
                        end
                    end else begin
                        if (trial_ok) begin
                            acc  <= add_sum[WIDTH-1:0];
                            qreg <= {qreg[WIDTH-2:0], 1'b1};
                        end else begin
                            acc  <= {acc[WIDTH-2:0], qreg[WIDTH-1]};
                            qreg <= {qreg[WIDTH-2:0], 1'b0};
                        end
                    end
                end
                ST_FIX: begin
                    res_one  <= neg0_out;
                    res_two  <= neg1_out;
                    div_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign ArithAnswerOne = res_one;
    assign ArithAnswerTwo = res_two;
    assign DivZero        = div_zero;

endmodule
